// File: rtl/collision_pkg.sv
// rtl/collision_pkg.sv - shared types, default sizes and score helpers for collision_ctrl.
// SCORE_BCD_EN selects 4-digit BCD scoring; undefined gives binary scoring.
package collision_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_INVUL = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    localparam int DEF_CAR_W = 40;
    localparam int DEF_CAR_H = 60;
    localparam int DEF_OBS_W = 50;
    localparam int DEF_OBS_H = 50;

    localparam logic [15:0] SCORE_MAX_BIN = 16'hFFFF;
    localparam logic [15:0] SCORE_MAX_BCD = 16'h9999;
`ifdef SCORE_BCD_EN
    localparam logic [15:0] SCORE_MAX = SCORE_MAX_BCD;
`else
    localparam logic [15:0] SCORE_MAX = SCORE_MAX_BIN;
`endif

    // Saturating +1 in whichever encoding the build selects.
    function automatic logic [15:0] score_inc(input logic [15:0] s);
`ifdef SCORE_BCD_EN
        logic [15:0] r;
        logic        carry;
        r     = s;
        carry = 1'b1;
        if (s != SCORE_MAX) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[i*4 +: 4] == 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
`else
        return (s == SCORE_MAX) ? s : s + 16'd1;
`endif
    endfunction

endpackage

// File: rtl/aabb_overlap.sv
// rtl/aabb_overlap.sv - combinational strict-inequality overlap test of two boxes.
module aabb_overlap
    import collision_pkg::*;
#(
    parameter int A_W = DEF_CAR_W,
    parameter int A_H = DEF_CAR_H,
    parameter int B_W = DEF_OBS_W,
    parameter int B_H = DEF_OBS_H
) (
    input  logic [9:0] a_h_i,
    input  logic [8:0] a_v_i,
    input  logic [9:0] b_h_i,
    input  logic [8:0] b_v_i,
    output logic       overlap_o
);

    // 11-bit operands keep edge+size sums from wrapping at the top of the range.
    logic [10:0] ah, av, bh, bv;

    assign ah = {1'b0, a_h_i};
    assign av = {2'b00, a_v_i};
    assign bh = {1'b0, b_h_i};
    assign bv = {2'b00, b_v_i};

    assign overlap_o = (ah < bh + 11'(B_W)) && (bh < ah + 11'(A_W)) &&
                       (av < bv + 11'(B_H)) && (bv < av + 11'(A_H));

endmodule

// File: rtl/collision_ctrl.sv
// rtl/collision_ctrl.sv - game state, lives, score and immunity control for the car game.
// Score encoding follows SCORE_BCD_EN (see collision_pkg).
module collision_ctrl
    import collision_pkg::*;
#(
    parameter int CAR_W        = DEF_CAR_W,
    parameter int CAR_H        = DEF_CAR_H,
    parameter int OBS_W        = DEF_OBS_W,
    parameter int OBS_H        = DEF_OBS_H,
    parameter int LIVES_INI    = 3,
    parameter int INVUL_FRAMES = 60
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        frame_tick,
    input  logic        start_btn,
    input  logic [9:0]  player_h_pos,
    input  logic [8:0]  player_v_pos,
    input  logic [9:0]  obs1_h_pos,
    input  logic [9:0]  obs2_h_pos,
    input  logic [8:0]  obs1_v_pos,
    input  logic [8:0]  obs2_v_pos,
    output logic        reset_game,
    output logic        game_over,
    output logic [1:0]  lives,
    output logic [15:0] score,
    output logic        hit_flash
);

    localparam int CNT_W = $clog2(INVUL_FRAMES + 1);

    state_e             state_q, state_d;
    logic [1:0]         lives_q, lives_d;
    logic [15:0]        score_q, score_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               reset_game_q, reset_game_d;
    logic               hit_flash_q, game_over_q;
    logic               start_prev_q, armed_q;
    logic               ov1, ov2, hit, start_evt, restart;

    aabb_overlap #(.A_W(CAR_W), .A_H(CAR_H), .B_W(OBS_W), .B_H(OBS_H)) u_ov1 (
        .a_h_i(player_h_pos), .a_v_i(player_v_pos),
        .b_h_i(obs1_h_pos),   .b_v_i(obs1_v_pos),
        .overlap_o(ov1)
    );

    aabb_overlap #(.A_W(CAR_W), .A_H(CAR_H), .B_W(OBS_W), .B_H(OBS_H)) u_ov2 (
        .a_h_i(player_h_pos), .a_v_i(player_v_pos),
        .b_h_i(obs2_h_pos),   .b_v_i(obs2_v_pos),
        .overlap_o(ov2)
    );

    // armed_q masks the first cycle after reset so a button already held is not an edge.
    assign start_evt = start_btn & ~start_prev_q & armed_q;
    assign hit       = frame_tick & (ov1 | ov2);
    assign restart   = start_evt & ((state_q == ST_IDLE) || (state_q == ST_OVER));

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q      <= ST_IDLE;
            lives_q      <= 2'd0;
            score_q      <= 16'd0;
            cnt_q        <= '0;
            reset_game_q <= 1'b0;
            hit_flash_q  <= 1'b0;
            game_over_q  <= 1'b0;
            start_prev_q <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            score_q      <= score_d;
            cnt_q        <= cnt_d;
            reset_game_q <= reset_game_d;
            hit_flash_q  <= (state_d == ST_INVUL);
            game_over_q  <= (state_d == ST_OVER);
            start_prev_q <= start_btn;
            armed_q      <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_evt) state_d = ST_PLAY;
            ST_PLAY:  if (hit) state_d = (lives_q > 2'd1) ? ST_INVUL : ST_OVER;
            ST_INVUL: if (frame_tick && cnt_q <= CNT_W'(1)) state_d = ST_PLAY;
            ST_OVER:  if (start_evt) state_d = ST_PLAY;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        lives_d      = lives_q;
        score_d      = score_q;
        cnt_d        = cnt_q;
        reset_game_d = restart;
        if (restart) begin
            lives_d = 2'(LIVES_INI);
            score_d = 16'd0;
            cnt_d   = '0;
        end else if (frame_tick) begin
            case (state_q)
                ST_PLAY: begin
                    if (hit) begin
                        if (lives_q > 2'd1) begin
                            lives_d = lives_q - 2'd1;
                            cnt_d   = CNT_W'(INVUL_FRAMES);
                        end else begin
                            lives_d = 2'd0;
                        end
                    end else begin
                        score_d = score_inc(score_q);
                    end
                end
                ST_INVUL: begin
                    score_d = score_inc(score_q);
                    cnt_d   = cnt_q - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign reset_game = reset_game_q;
    assign game_over  = game_over_q;
    assign hit_flash  = hit_flash_q;
    assign lives      = lives_q;
    assign score      = score_q;

endmodule

// File: tb/tb_collision_ctrl.sv
// tb/tb_collision_ctrl.sv - self-checking bench for collision_ctrl (vector table, directed and random).
module tb_collision_ctrl;

    logic        clk = 1'b0;
    logic        iRST_n;
    logic        frame_tick, start_btn;
    logic [9:0]  player_h_pos, obs1_h_pos, obs2_h_pos;
    logic [8:0]  player_v_pos, obs1_v_pos, obs2_v_pos;
    logic        reset_game, game_over, hit_flash;
    logic [1:0]  lives;
    logic [15:0] score;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    int m_started, m_over, m_lives, m_score, m_imm, m_prev, m_armed, m_rg;

`ifdef SCORE_BCD_EN
    localparam int MAX_SCORE = 16'h9999;
    localparam int MAX_TICKS = 9999;
`else
    localparam int MAX_SCORE = 16'hFFFF;
    localparam int MAX_TICKS = 65535;
`endif

    always #20 clk = ~clk;

    collision_ctrl dut (
        .iVGA_CLK(clk), .iRST_n(iRST_n), .frame_tick(frame_tick), .start_btn(start_btn),
        .player_h_pos(player_h_pos), .player_v_pos(player_v_pos),
        .obs1_h_pos(obs1_h_pos), .obs2_h_pos(obs2_h_pos),
        .obs1_v_pos(obs1_v_pos), .obs2_v_pos(obs2_v_pos),
        .reset_game(reset_game), .game_over(game_over), .lives(lives),
        .score(score), .hit_flash(hit_flash)
    );

    typedef struct {
        int st, tk, ph, pv, o1h, o1v, o2h, o2v;
        int rg, go, lv, sc, hf;
    } vec_t;

    vec_t tbl[10];

    function automatic int sat_inc(input int s);
`ifdef SCORE_BCD_EN
        int d;
        d = ((s >> 12) & 15) * 1000 + ((s >> 8) & 15) * 100 + ((s >> 4) & 15) * 10 + (s & 15);
        d = (d >= 9999) ? 9999 : d + 1;
        return ((d / 1000) << 12) | (((d / 100) % 10) << 8) | (((d / 10) % 10) << 4) | (d % 10);
`else
        return (s >= 65535) ? 65535 : s + 1;
`endif
    endfunction

    function automatic int boxes_touch(input int ph, input int pv, input int oh, input int ov);
        return (ph < oh + 50 && oh < ph + 40 && pv < ov + 50 && ov < pv + 60) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_started = 0; m_over = 0; m_lives = 0; m_score = 0;
        m_imm = 0; m_prev = 0; m_armed = 0; m_rg = 0;
    endtask

    task automatic model_step(input int st, input int tk, input int ph, input int pv,
                              input int o1h, input int o1v, input int o2h, input int o2v);
        int ev, hit;
        ev  = (st != 0 && m_prev == 0 && m_armed != 0) ? 1 : 0;
        hit = boxes_touch(ph, pv, o1h, o1v) | boxes_touch(ph, pv, o2h, o2v);
        m_prev  = st;
        m_armed = 1;
        m_rg    = 0;
        if (ev != 0 && (m_started == 0 || m_over != 0)) begin
            m_started = 1; m_over = 0; m_lives = 3; m_score = 0; m_imm = 0; m_rg = 1;
        end else if (m_started != 0 && m_over == 0 && tk != 0) begin
            if (m_imm > 0) begin
                m_score = sat_inc(m_score);
                m_imm   = m_imm - 1;
            end else if (hit != 0) begin
                if (m_lives > 1) begin
                    m_lives = m_lives - 1;
                    m_imm   = 60;
                end else begin
                    m_lives = 0;
                    m_over  = 1;
                end
            end else begin
                m_score = sat_inc(m_score);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [20:0] exp;
        exp = {m_rg[0], m_over[0], m_lives[1:0], m_score[15:0], (m_imm > 0)};
        chk("model", {11'd0, reset_game, game_over, lives, score, hit_flash}, {11'd0, exp});
    endtask

    // Drive inputs for one edge, clock it, then compare against the model.
    task automatic cycle(input int st, input int tk, input int ph, input int pv,
                         input int o1h, input int o1v, input int o2h, input int o2v);
        start_btn    = st[0];
        frame_tick   = tk[0];
        player_h_pos = 10'(ph);
        player_v_pos = 9'(pv);
        obs1_h_pos   = 10'(o1h);
        obs1_v_pos   = 9'(o1v);
        obs2_h_pos   = 10'(o2h);
        obs2_v_pos   = 9'(o2v);
        @(posedge clk);
        if (!iRST_n) model_reset();
        else model_step(st, tk, ph, pv, o1h, o1v, o2h, o2v);
        #1;
        check_model();
    endtask

    task automatic far_ticks(input int n);
        for (int i = 0; i < n; i++) cycle(0, 1, 100, 400, 600, 0, 600, 0);
    endtask

    task automatic do_reset();
        #4;
        iRST_n = 1'b0;
        #2;
        model_reset();
        chk("async_reset", {reset_game, game_over, lives, score, hit_flash}, 21'd0);
        @(posedge clk);
        #1;
        iRST_n = 1'b1;
    endtask

    initial begin
        tbl[0] = '{0, 0, 100, 400, 600,   0, 600,   0,  0, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 100, 400, 600,   0, 600,   0,  1, 0, 3, 0, 0};
        tbl[2] = '{1, 0, 100, 400, 600,   0, 600,   0,  0, 0, 3, 0, 0};
        tbl[3] = '{0, 1, 100, 400, 600,   0, 600,   0,  0, 0, 3, 1, 0};
        tbl[4] = '{0, 1, 100, 400, 600,   0, 600,   0,  0, 0, 3, 2, 0};
        tbl[5] = '{0, 0, 100, 400, 100, 380, 600,   0,  0, 0, 3, 2, 0};
        tbl[6] = '{0, 1, 100, 400, 100, 380, 120, 390,  0, 0, 2, 2, 1};
        tbl[7] = '{0, 1, 100, 400, 100, 380, 600,   0,  0, 0, 2, 3, 1};
        tbl[8] = '{1, 0, 100, 400, 600,   0, 600,   0,  0, 0, 2, 3, 1};
        tbl[9] = '{0, 1, 100, 400, 600,   0, 600,   0,  0, 0, 2, 4, 1};

        iRST_n = 1'b1;
        start_btn = 1'b0; frame_tick = 1'b0;
        player_h_pos = 10'd100; player_v_pos = 9'd400;
        obs1_h_pos = 10'd600; obs1_v_pos = 9'd0; obs2_h_pos = 10'd600; obs2_v_pos = 9'd0;
        model_reset();
        @(posedge clk);
        do_reset();

        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].st, tbl[i].tk, tbl[i].ph, tbl[i].pv,
                  tbl[i].o1h, tbl[i].o1v, tbl[i].o2h, tbl[i].o2v);
            chk($sformatf("table[%0d]", i), {reset_game, game_over, lives, score, hit_flash},
                {tbl[i].rg[0], tbl[i].go[0], tbl[i].lv[1:0], tbl[i].sc[15:0], tbl[i].hf[0]});
        end

        // Immunity from the row-6 hit has 58 frames left here.
        far_ticks(57);
        chk("invul_last_frame", {31'd0, hit_flash}, 32'd1);
        far_ticks(1);
        chk("invul_expired", {31'd0, hit_flash}, 32'd0);
        chk("score_after_invul", {16'd0, score}, 32'd62);

        // Touching edges are not an overlap; one pixel in is.
        cycle(0, 1, 170, 400, 120, 380, 600, 0);
        chk("edge_touch_lives", {30'd0, lives}, 32'd2);
        cycle(0, 1, 169, 400, 120, 380, 600, 0);
        chk("edge_in_lives", {30'd0, lives}, 32'd1);
        chk("edge_in_flash", {31'd0, hit_flash}, 32'd1);
        far_ticks(60);

        cycle(0, 1, 100, 400, 100, 380, 600, 0);
        chk("last_life_over", {29'd0, game_over, lives}, {29'd0, 1'b1, 2'd0});
        chk("over_score", {16'd0, score}, 32'd123);
        far_ticks(5);
        chk("over_frozen", {16'd0, score}, 32'd123);
        cycle(1, 0, 100, 400, 600, 0, 600, 0);
        chk("restart", {reset_game, game_over, lives, score, hit_flash},
            {1'b1, 1'b0, 2'd3, 16'd0, 1'b0});
        cycle(1, 0, 100, 400, 600, 0, 600, 0);
        chk("restart_pulse_len", {31'd0, reset_game}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            int ph, pv, o1h, o1v, o2h, o2v, st, tk;
            ph  = $urandom_range(0, 1023);
            pv  = $urandom_range(0, 511);
            o1h = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 1023)
                                              : (ph + $urandom_range(0, 120) + 1024 - 60) % 1024;
            o1v = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 511)
                                              : (pv + $urandom_range(0, 120) + 512 - 60) % 512;
            o2h = $urandom_range(0, 1023);
            o2v = $urandom_range(0, 511);
            st  = ($urandom_range(0, 19) == 0) ? 1 : 0;
            tk  = ($urandom_range(0, 2) == 0) ? 1 : 0;
            cycle(st, tk, ph, pv, o1h, o1v, o2h, o2v);
        end

        // Reset in the middle of immunity, with start held through release.
        do_reset();
        cycle(0, 0, 100, 400, 600, 0, 600, 0);
        cycle(1, 0, 100, 400, 600, 0, 600, 0);
        cycle(0, 1, 100, 400, 100, 380, 600, 0);
        far_ticks(3);
        chk("pre_reset_invul", {31'd0, hit_flash}, 32'd1);
        #4;
        iRST_n = 1'b0;
        start_btn = 1'b1;
        #2;
        model_reset();
        chk("mid_invul_reset", {reset_game, game_over, lives, score, hit_flash}, 21'd0);
        @(posedge clk);
        #1;
        iRST_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1, 0, 100, 400, 600, 0, 600, 0);
        chk("held_start_no_event", {29'd0, reset_game, lives}, 32'd0);

        // Saturation: run the score past its maximum.
        cycle(0, 0, 100, 400, 600, 0, 600, 0);
        cycle(1, 0, 100, 400, 600, 0, 600, 0);
        far_ticks(MAX_TICKS + 3);
        chk("score_saturates", {16'd0, score}, MAX_SCORE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
